// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the shift-subtract divider:
//   div_state_e : controller states (IDLE, RUN, DONE)
//   DIV_N       : default operand width
//   cnt_w()     : width of a counter that must hold the value n
// -----------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_N = 8;

  // Counter width able to represent 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 32'sd1);
  endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//   r_i       [N-1:0] partial remainder (always < divisor between steps)
//   q_msb_i          bit shifted out of the quotient/dividend register
//   divisor_i [N-1:0] divisor
//   r_o       [N-1:0] next partial remainder
//   q_bit_o          quotient bit produced by this step
// The shifted remainder can reach 2*divisor-1, so the compare and subtract
// are N+1 bits wide; the result after a step is again < divisor and fits N.
// -----------------------------------------------------------------------------
module div_step #(
  parameter int N = 8
) (
  input  logic [N-1:0] r_i,
  input  logic         q_msb_i,
  input  logic [N-1:0] divisor_i,
  output logic [N-1:0] r_o,
  output logic         q_bit_o
);

  logic [N:0] t_s;
  logic [N:0] d_ext_s;

  assign t_s     = {r_i, q_msb_i};
  assign d_ext_s = {1'b0, divisor_i};

  // Shift, compare, conditionally subtract.
  always_comb begin
    r_o     = t_s[N-1:0];
    q_bit_o = 1'b0;
    if (t_s >= d_ext_s) begin
      r_o     = N'(t_s - d_ext_s);
      q_bit_o = 1'b1;
    end else begin
      r_o     = t_s[N-1:0];
      q_bit_o = 1'b0;
    end
  end

endmodule

// File: rtl/shift_sub_divider.sv
// -----------------------------------------------------------------------------
// shift_sub_divider
// Sequential restoring divider: 2N-bit dividend / N-bit divisor -> N-bit
// quotient and remainder, one quotient bit per clock.
//   clk, rst (async, active-high)
//   start      request, accepted in IDLE or DONE
//   dividend   [2N-1:0], divisor [N-1:0] sampled with an accepted start
//   quotient, remainder [N-1:0] registered, updated only on completion
//   ovf        divide-by-zero / quotient overflow, valid while d_end=1
//   busy       high while iterating
//   d_end      result-valid level
// Optional macro DIV_SIGNED_EN: two's complement operands, truncating
// division, remainder follows the dividend's sign.
// -----------------------------------------------------------------------------
module shift_sub_divider
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           ovf,
  output logic           busy,
  output logic           d_end
);

  localparam int CW = cnt_w(N);
  localparam logic [N-1:0] ZERO_N   = {N{1'b0}};
  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] MAX_POS  = {1'b0, {(N-1){1'b1}}};
`ifdef DIV_SIGNED_EN
  localparam logic [N-1:0] OVF_Q = MOST_NEG;
`else
  localparam logic [N-1:0] OVF_Q = {N{1'b1}};
`endif

  div_state_e    state_q, state_d;
  logic [N-1:0]  r_q, r_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;
  logic          dend_q, dend_d;

  logic [2*N-1:0] dvd_mag_s;
  logic [N-1:0]   dsr_mag_s;
  logic           pre_ovf_s;
  logic           accept_s;
  logic [N-1:0]   step_r_s;
  logic           step_qb_s;
  logic [N-1:0]   next_q_s;
  logic [N-1:0]   fin_quot_s;
  logic [N-1:0]   fin_rem_s;
  logic           fin_ovf_s;

  assign accept_s = start && (state_q != RUN);

  div_step #(.N(N)) u_step (
    .r_i       (r_q),
    .q_msb_i   (q_q[N-1]),
    .divisor_i (div_q),
    .r_o       (step_r_s),
    .q_bit_o   (step_qb_s)
  );

  assign next_q_s = {q_q[N-2:0], step_qb_s};

`ifdef DIV_SIGNED_EN
  logic neg_q_q, neg_r_q;
  logic range_ovf_s;

  // Operand magnitudes; the unsigned core always works on these.
  always_comb begin
    dvd_mag_s = dividend[2*N-1] ? -dividend : dividend;
    dsr_mag_s = divisor[N-1] ? -divisor : divisor;
  end

  // Result signs captured at load, applied on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (accept_s) begin
      neg_q_q <= dividend[2*N-1] ^ divisor[N-1];
      neg_r_q <= dividend[2*N-1];
    end else begin
      neg_q_q <= neg_q_q;
      neg_r_q <= neg_r_q;
    end
  end

  // Signed range check and sign restoration of the finished result.
  always_comb begin
    range_ovf_s = neg_q_q ? (next_q_s > MOST_NEG) : (next_q_s > MAX_POS);
    fin_ovf_s   = range_ovf_s;
    if (range_ovf_s) begin
      fin_quot_s = MOST_NEG;
      fin_rem_s  = ZERO_N;
    end else begin
      fin_quot_s = neg_q_q ? -next_q_s : next_q_s;
      fin_rem_s  = neg_r_q ? -step_r_s : step_r_s;
    end
  end
`else
  // Unsigned operands pass straight through.
  always_comb begin
    dvd_mag_s  = dividend;
    dsr_mag_s  = divisor;
    fin_quot_s = next_q_s;
    fin_rem_s  = step_r_s;
    fin_ovf_s  = 1'b0;
  end
`endif

  // Zero divisor or a high half >= divisor means the quotient cannot fit.
  assign pre_ovf_s = (dsr_mag_s == ZERO_N) || (dvd_mag_s[2*N-1:N] >= dsr_mag_s);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= ZERO_N;
      q_q     <= ZERO_N;
      div_q   <= ZERO_N;
      cnt_q   <= {CW{1'b0}};
      quot_q  <= ZERO_N;
      rem_q   <= ZERO_N;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      dend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      dend_q  <= dend_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    dend_d  = dend_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          div_d  = dsr_mag_s;
          ovf_d  = 1'b0;
          dend_d = 1'b0;
          if (pre_ovf_s) begin
            state_d = DONE;
            quot_d  = OVF_Q;
            rem_d   = ZERO_N;
            ovf_d   = 1'b1;
            dend_d  = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = {CW{1'b0}};
          end else begin
            state_d = RUN;
            r_d     = dvd_mag_s[2*N-1:N];
            q_d     = dvd_mag_s[N-1:0];
            cnt_d   = CW'(N);
            busy_d  = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        r_d   = step_r_s;
        q_d   = next_q_s;
        cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == {{(CW-1){1'b0}}, 1'b1}) begin
          state_d = DONE;
          busy_d  = 1'b0;
          dend_d  = 1'b1;
          quot_d  = fin_quot_s;
          rem_d   = fin_rem_s;
          ovf_d   = fin_ovf_s;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        dend_d  = 1'b0;
      end
    endcase
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;
  assign d_end     = dend_q;

endmodule
